// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives the instruction memory address, holds one fetched word for decode,
// and supports redirects. Optional halt detection is enabled by defining IF_HALT_DETECT_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] PC_out,
  input  logic [31:0] IS_in,
  output logic [31:0] IR_out,
  output logic        IR_valid,
  input  logic        IR_ready,
  output logic [31:0] IR_PC4,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_e;

`ifdef IF_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc4_q, ir_pc4_d;
  logic        ir_valid_q, ir_valid_d;
  logic        halted_q, halted_d;

  logic [31:0] pc_plus4_s;
  logic        handshake_s;
  logic        halt_hit_s;
  logic        unused_redirect_lsb_s;

  assign pc_plus4_s  = pc_q + 32'd4;
  assign handshake_s = ir_valid_q & IR_ready;
  // Halt is recognised on the held word only when it is being consumed.
  assign halt_hit_s  = HALT_EN & (ir_q[31:26] == HALT_OPCODE);
  assign unused_redirect_lsb_s = ^Redirect_PC[1:0];

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc4_d   = ir_pc4_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;

    if (Redirect) begin
      pc_d       = {Redirect_PC[31:2], 2'b00};
      ir_valid_d = 1'b0;
      halted_d   = 1'b0;
      state_d    = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          ir_d       = IS_in;
          ir_pc4_d   = pc_plus4_s;
          pc_d       = pc_plus4_s;
          ir_valid_d = 1'b1;
          state_d    = HOLD;
        end
        HOLD: begin
          if (handshake_s && halt_hit_s) begin
            ir_valid_d = 1'b0;
            halted_d   = 1'b1;
            state_d    = HALT;
          end else if (handshake_s) begin
            ir_d       = IS_in;
            ir_pc4_d   = pc_plus4_s;
            pc_d       = pc_plus4_s;
            ir_valid_d = 1'b1;
            state_d    = HOLD;
          end else begin
            state_d = HOLD;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          ir_valid_d = 1'b0;
          halted_d   = 1'b0;
          state_d    = FETCH;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0000_0000;
      ir_pc4_q   <= 32'h0000_0000;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc4_q   <= ir_pc4_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign PC_out   = pc_q;
  assign IR_out   = ir_q;
  assign IR_PC4   = ir_pc4_q;
  assign IR_valid = ir_valid_q;
  assign Halted   = halted_q & HALT_EN;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed steps followed by a randomized phase
// checked against a stream-level model of the delivered instruction sequence.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_out, is_in, ir_out, ir_pc4, redirect_pc;
  logic        ir_valid, ir_ready, redirect, halted;

  logic        w_rst_n;
  logic [31:0] w_pc_out, w_is_in, w_ir_out, w_ir_pc4;
  logic        w_ir_valid, w_halted, w_ir_ready, w_redirect;
  logic [31:0] w_redirect_pc;

  logic [31:0] mem [0:1023];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign is_in   = mem[pc_out[11:2]];
  assign w_is_in = mem[w_pc_out[11:2]];

  if_fetch_unit dut (
    .CLK(clk), .Reset(rst_n), .PC_out(pc_out), .IS_in(is_in), .IR_out(ir_out),
    .IR_valid(ir_valid), .IR_ready(ir_ready), .IR_PC4(ir_pc4), .Redirect(redirect),
    .Redirect_PC(redirect_pc), .Halted(halted)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK(clk), .Reset(w_rst_n), .PC_out(w_pc_out), .IS_in(w_is_in), .IR_out(w_ir_out),
    .IR_valid(w_ir_valid), .IR_ready(w_ir_ready), .IR_PC4(w_ir_pc4), .Redirect(w_redirect),
    .Redirect_PC(w_redirect_pc), .Halted(w_halted)
  );

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    logic [9:0] idx;
    idx = a[11:2];
    return mem[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic        exp_valid;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    rst_n = 1'b0; w_rst_n = 1'b0;
    ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0000_0000;
    w_ir_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = 32'h0000_0000;

    // Reset state
    #12;
    check("rst_pc", pc_out, 32'h0000_0000);
    check("rst_ir", ir_out, 32'h0000_0000);
    check("rst_pc4", ir_pc4, 32'h0000_0000);
    check("rst_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("wrap_rst_pc", w_pc_out, 32'hFFFF_FFFC);

    // Streaming after release with IR_ready high
    cyc();
    rst_n = 1'b1; w_rst_n = 1'b1; ir_ready = 1'b1;
    check("stream_pc0", pc_out, 32'h0000_0000);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check("stream_pc", pc_out, 32'd4 * k);
      check("stream_ir", ir_out, mem[k-1]);
      check("stream_pc4", ir_pc4, 32'd4 * k);
      check("stream_valid", {31'd0, ir_valid}, 32'd1);
      if (k == 1) begin
        check("wrap_pc", w_pc_out, 32'h0000_0000);
        check("wrap_ir", w_ir_out, mem[1023]);
        check("wrap_pc4", w_ir_pc4, 32'h0000_0000);
      end
    end

    // Stall for three cycles
    ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("stall_pc", pc_out, 32'h0000_000C);
      check("stall_ir", ir_out, mem[2]);
      check("stall_pc4", ir_pc4, 32'h0000_000C);
      check("stall_valid", {31'd0, ir_valid}, 32'd1);
    end
    ir_ready = 1'b1;
    cyc();
    check("resume_ir", ir_out, mem[3]);
    check("resume_pc4", ir_pc4, 32'h0000_0010);
    cyc();
    check("resume_ir2", ir_out, mem[4]);
    check("resume_pc", pc_out, 32'h0000_0014);

    // Redirect to an unaligned target coincident with a handshake
    redirect = 1'b1; redirect_pc = 32'h0000_0047;
    cyc();
    redirect = 1'b0;
    check("redir_pc", pc_out, 32'h0000_0044);
    check("redir_valid", {31'd0, ir_valid}, 32'd0);
    cyc();
    check("redir_ir", ir_out, mem[17]);
    check("redir_pc4", ir_pc4, 32'h0000_0048);
    check("redir_valid2", {31'd0, ir_valid}, 32'd1);

    // Asynchronous reset between edges while holding
    ir_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_pc", pc_out, 32'h0000_0000);
    check("async_ir", ir_out, 32'h0000_0000);
    check("async_pc4", ir_pc4, 32'h0000_0000);
    check("async_valid", {31'd0, ir_valid}, 32'd0);
    #1 rst_n = 1'b1; ir_ready = 1'b1;
    cyc();
    check("post_rst_ir", ir_out, mem[0]);
    check("post_rst_pc", pc_out, 32'h0000_0004);

    // Halt opcode at 0x8
    mem[2] = 32'hFC00_0000;
    cyc();
    cyc();
    check("halt_word", ir_out, 32'hFC00_0000);
    check("halt_pre", {31'd0, halted}, 32'd0);
    cyc();
`ifdef IF_HALT_DETECT_EN
    for (int k = 0; k < 3; k++) begin
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_valid", {31'd0, ir_valid}, 32'd0);
      check("halt_pc", pc_out, 32'h0000_000C);
      cyc();
    end
`else
    check("nohalt_halted", {31'd0, halted}, 32'd0);
    check("nohalt_ir", ir_out, mem[3]);
    check("nohalt_pc", pc_out, 32'h0000_0010);
    check("nohalt_valid", {31'd0, ir_valid}, 32'd1);
`endif
    redirect = 1'b1; redirect_pc = 32'h0000_0000;
    cyc();
    redirect = 1'b0;
    check("unhalt_halted", {31'd0, halted}, 32'd0);
    check("unhalt_pc", pc_out, 32'h0000_0000);
    cyc();
    check("unhalt_ir", ir_out, mem[0]);
    check("unhalt_valid", {31'd0, ir_valid}, 32'd1);
    mem[2] = $urandom & 32'h7FFF_FFFF;

    // Randomized phase: the delivered stream must be mem[T], mem[T+4], ... after each redirect to T
    exp_addr = 32'h0000_0000;
    exp_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      check("rnd_valid", {31'd0, ir_valid}, {31'd0, exp_valid});
      check("rnd_pc", pc_out, exp_valid ? exp_addr + 32'd4 : exp_addr);
      check("rnd_halted", {31'd0, halted}, 32'd0);
      if (exp_valid) begin
        check("rnd_ir", ir_out, mem_at(exp_addr));
        check("rnd_pc4", ir_pc4, exp_addr + 32'd4);
      end
      ir_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      if (redirect) begin
        exp_addr = redirect_pc & 32'hFFFF_FFFC;
        exp_valid = 1'b0;
      end else if (!exp_valid) begin
        exp_valid = 1'b1;
      end else if (ir_ready) begin
        exp_addr = exp_addr + 32'd4;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
